// File: rtl/fir_mac_scheduler_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR MAC scheduler.
// Holds the controller state encoding and the accumulator and index width formulas.
package fir_mac_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Headroom of log2(TAPS) bits keeps a full-scale TAPS-term sum from overflowing.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic int idx_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Bundle of the coefficient write port plus sample-in and result-out handshakes.
// Both streams use valid/ready: a transfer happens on a rising clock edge where valid & ready.
interface fir_mac_scheduler_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int ACC_W  = fir_mac_scheduler_pkg::acc_width(DATA_W, COEF_W, TAPS)
);
  localparam int IDX_W = fir_mac_scheduler_pkg::idx_width(TAPS);

  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_addr;
  logic [COEF_W-1:0] cfg_data;
  logic              cfg_busy;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    input  cfg_busy, in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    output cfg_busy, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fir_mac_scheduler_delay_line.sv
// TAPS-deep sample ring buffer: one synchronous write port, one combinational read port.
// Every entry clears on reset so a restarted filter sees zero history.
module fir_delay_line #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 8,
  parameter int IDX_W  = fir_mac_scheduler_pkg::idx_width(TAPS)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wr_ptr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_line [TAPS];

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int k = 0; k < TAPS; k++) begin
        r_line[k] <= '0;
      end
    end else if (i_we) begin
      r_line[i_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_line[i_rd_idx];

endmodule

// File: rtl/fir_mac_scheduler.sv
// FIR controller: one shared signed MAC walks TAPS coefficients per accepted sample.
// Owns the coefficient bank, the sample ring buffer and the IDLE -> MAC -> OUT sequencer.
module fir_mac_scheduler
  import fir_mac_scheduler_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int ACC_W  = acc_width(DATA_W, COEF_W, TAPS)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  fir_mac_scheduler_if.slave  io_bus,
  output state_t              o_state
);

  localparam int IDX_W  = idx_width(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_in_ready;
  logic [IDX_W-1:0]          r_wr_ptr;
  logic [IDX_W-1:0]          r_tap;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [COEF_W-1:0]  r_coef [TAPS];

  logic                      w_accept;
  logic                      w_out_fire;
  logic                      w_cfg_fire;
  logic [IDX_W-1:0]          w_rd_idx;
  logic signed [DATA_W-1:0]  w_rd_data;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;

  // in_ready is a register and only ever set while IDLE, so accept implies IDLE.
  assign w_accept   = io_bus.in_valid & r_in_ready;
  assign w_out_fire = (r_state == ST_OUT) & io_bus.out_ready;
  assign w_cfg_fire = io_bus.cfg_we & (r_state == ST_IDLE);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_MAC;
      ST_MAC:  if (r_tap == IDX_W'(TAPS - 1)) w_state_nxt = ST_OUT;
      ST_OUT:  if (io_bus.out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
    end else if (w_out_fire) begin
      r_wr_ptr <= r_wr_ptr + IDX_W'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int k = 0; k < TAPS; k++) begin
        r_coef[k] <= '0;
      end
    end else if (w_cfg_fire) begin
      r_coef[io_bus.cfg_addr] <= io_bus.cfg_data;
    end
  end

  // Tap k pairs with the sample k steps older; index wraps because TAPS is a power of two.
  assign w_rd_idx   = r_wr_ptr - r_tap;
  assign w_coef     = r_coef[r_tap];
  assign w_prod     = PROD_W'(w_coef) * PROD_W'(w_rd_data);
  assign w_prod_ext = ACC_W'(w_prod);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_tap <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_tap <= '0;
      r_acc <= '0;
    end else if (r_state == ST_MAC) begin
      r_tap <= r_tap + IDX_W'(1);
      r_acc <= r_acc + w_prod_ext;
    end
  end

  fir_delay_line #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .IDX_W  (IDX_W)
  ) u_delay_line (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_we      (w_accept),
    .i_wr_ptr  (r_wr_ptr),
    .i_wr_data (io_bus.in_data),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.cfg_busy  = (r_state != ST_IDLE);
  assign io_bus.out_valid = (r_state == ST_OUT);
  assign io_bus.out_data  = r_acc;
  assign o_state          = r_state;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler at TAPS=4: directed corners plus random traffic,
// checked against a convolution model over the recent-sample history.
module tb_fir_mac_scheduler;
  import fir_mac_scheduler_pkg::*;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 4;
  localparam int ACC_W  = 34;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  fir_mac_scheduler_if #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W)
  ) bus ();

  fir_mac_scheduler #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .io_bus  (bus),
    .o_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [ACC_W-1:0] exp_q[$];
  int               lat_q[$];

  // Reference: coefficient values and history, hist[k] = x[n-k].
  longint m_coef [TAPS];
  longint m_hist [TAPS];

  bit rand_rdy = 1'b0;
  bit prev_v   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      m_coef[k] = 0;
      m_hist[k] = 0;
    end
  endtask

  task automatic model_accept(input logic [DATA_W-1:0] x);
    longint           sum;
    logic [ACC_W-1:0] y;
    for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = longint'($signed(x));
    sum = 0;
    for (int k = 0; k < TAPS; k++) sum += m_coef[k] * m_hist[k];
    y = sum[ACC_W-1:0];
    exp_q.push_back(y);
  endtask

  // Monitor: results are compared when a handshake is observed; latency on each rise.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.out_valid === 1'b1 && !prev_v) begin
          if (lat_q.size() > 0) begin
            check("latency", 64'(cyc - lat_q.pop_front()), 64'(TAPS));
          end else begin
            total++;
            bad++;
            $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
          end
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          if (exp_q.size() > 0) begin
            check("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
          end else begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %0h expected none", bus.out_data);
          end
        end
        prev_v = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data, input bit apply);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    tick();
    bus.cfg_we = 1'b0;
    if (apply) m_coef[addr] = longint'($signed(data));
  endtask

  task automatic send(input logic [15:0] x, input bit with_cfg,
                      input logic [1:0] addr, input logic [15:0] cd);
    bit got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    if (with_cfg) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = addr;
      bus.cfg_data = cd;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      if (with_cfg) m_coef[addr] = longint'($signed(cd));
      model_accept(x);
      lat_q.push_back(cyc + 1);
      tick();
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: pending=%0d expected 0", exp_q.size());
    end
    tick();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    model_clear();
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rx;
    logic [15:0] rc;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    model_clear();

    // Reset values and in_ready rising one cycle after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_cfg_busy",  64'(bus.cfg_busy),  64'd0);
    check("rst_state",     64'(dbg_state),     64'(ST_IDLE));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready_0", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("rel_in_ready_1", 64'(bus.in_ready), 64'd1);
    tick();

    // Impulse response, then a step that wraps the write pointer.
    for (int k = 0; k < TAPS; k++) cfg_write(2'(k), 16'(k + 1), 1'b1);
    send(16'd1, 1'b0, 2'd0, 16'd0);
    for (int k = 1; k < TAPS; k++) send(16'd0, 1'b0, 2'd0, 16'd0);
    for (int k = 0; k < 6; k++) send(16'd1, 1'b0, 2'd0, 16'd0);
    wait_idle();

    // Backpressure: result must hold while out_ready is low.
    bus.out_ready = 1'b0;
    send(16'd3, 1'b0, 2'd0, 16'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) break;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready",  64'(bus.in_ready),  64'd0);
      if (exp_q.size() > 0) check("bp_out_data", 64'(bus.out_data), 64'(exp_q[0]));
      @(negedge clk);
    end
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_single_result", 64'(bus.out_valid), 64'd0);
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    tick();

    // Signed extremes.
    for (int k = 0; k < TAPS; k++) cfg_write(2'(k), 16'd0, 1'b1);
    cfg_write(2'd0, 16'h8000, 1'b1);
    send(16'h8000, 1'b0, 2'd0, 16'd0);
    wait_idle();
    check("model_min_x_min", 64'(exp_q.size()), 64'd0);
    cfg_write(2'd0, 16'hFFFF, 1'b1);
    send(16'd5, 1'b0, 2'd0, 16'd0);
    wait_idle();

    // Coefficient write during MAC is dropped; with an accept it commits first.
    cfg_write(2'd0, 16'd3, 1'b1);
    send(16'd2, 1'b0, 2'd0, 16'd0);
    @(negedge clk);
    check("mac_cfg_busy", 64'(bus.cfg_busy), 64'd1);
    check("mac_state",    64'(dbg_state),    64'(ST_MAC));
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 2'd0;
    bus.cfg_data = 16'd7;
    tick();
    bus.cfg_we = 1'b0;
    wait_idle();
    send(16'd4, 1'b1, 2'd0, 16'd7);
    wait_idle();

    // Reset mid-MAC discards the result and clears history.
    for (int k = 0; k < TAPS; k++) cfg_write(2'(k), 16'd1, 1'b1);
    send(16'd9, 1'b0, 2'd0, 16'd0);
    tick();
    do_reset(2);
    for (int i = 0; i < TAPS + 4; i++) begin
      @(negedge clk);
      if (i % 4 == 0) check("rst_mid_no_valid", 64'(bus.out_valid), 64'd0);
    end
    check("rst_mid_state", 64'(dbg_state), 64'(ST_IDLE));
    tick();
    for (int k = 0; k < TAPS; k++) cfg_write(2'(k), 16'd1, 1'b1);
    send(16'd1, 1'b0, 2'd0, 16'd0);
    wait_idle();

    // Random traffic with random backpressure and occasional coefficient updates.
    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        rc = 16'($urandom_range(0, 65535));
        cfg_write(2'($urandom_range(0, TAPS - 1)), rc, 1'b1);
      end
      rx = 16'($urandom_range(0, 65535));
      rc = 16'($urandom_range(0, 65535));
      send(rx, ($urandom_range(0, 4) == 0), 2'($urandom_range(0, TAPS - 1)), rc);
    end
    wait_idle();
    rand_rdy      = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
